// File: rtl/cmat2x2_sequencer.sv
// 2x2 complex matrix product C = A x B using one shared complex multiplier.
// Operands are captured in one handshake; results stream out one element at a time under valid/ready.
module cmat2x2_sequencer #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*W-1:0]        a_real,
  input  logic [4*W-1:0]        a_imag,
  input  logic [4*W-1:0]        b_real,
  input  logic [4*W-1:0]        b_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_idx,
  output logic signed [2*W+1:0] c_real,
  output logic signed [2*W+1:0] c_imag,
  output logic                  busy
);

  // state | meaning
  // IDLE  | waiting for an operand set, in_ready high
  // MUL0  | acc <= A[i][0]*B[0][j]
  // MUL1  | acc <= acc + A[i][1]*B[1][j]
  // OUT   | C[i][j] presented until out_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL0 = 2'd1,
    MUL1 = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [4*W-1:0]        ar_q, ai_q, br_q, bi_q;
  logic [1:0]            k;
  logic signed [2*W+1:0] acc_re, acc_im;

  logic                  phase;
  logic [1:0]            a_sel, b_sel;
  logic signed [W-1:0]   op_ar, op_ai, op_br, op_bi;
  logic signed [2*W-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [2*W:0]   p_re, p_im;
  logic signed [2*W+1:0] p_re_x, p_im_x;
  logic                  accept, emit;

  function automatic logic signed [W-1:0] pick(input logic [4*W-1:0] v, input logic [1:0] s);
    logic signed [W-1:0] r;
    case (s)
      2'd0:    r = v[W-1:0];
      2'd1:    r = v[2*W-1:W];
      2'd2:    r = v[3*W-1:2*W];
      default: r = v[4*W-1:3*W];
    endcase
    return r;
  endfunction

  assign accept = (state == IDLE) && in_valid;
  assign emit   = (state == OUT) && out_ready;

  // Element index = 2*row + col, so A walks its row and B walks its column
  assign phase = (state == MUL1);
  assign a_sel = {k[1], phase};
  assign b_sel = {phase, k[0]};

  assign op_ar = pick(ar_q, a_sel);
  assign op_ai = pick(ai_q, a_sel);
  assign op_br = pick(br_q, b_sel);
  assign op_bi = pick(bi_q, b_sel);

  assign m_rr = op_ar * op_br;
  assign m_ii = op_ai * op_bi;
  assign m_ri = op_ar * op_bi;
  assign m_ir = op_ai * op_br;

  // Full-precision product: one guard bit so (-2^(W-1))^2 terms never wrap
  assign p_re = {m_rr[2*W-1], m_rr} - {m_ii[2*W-1], m_ii};
  assign p_im = {m_ri[2*W-1], m_ri} + {m_ir[2*W-1], m_ir};

  assign p_re_x = {p_re[2*W], p_re};
  assign p_im_x = {p_im[2*W], p_im};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = MUL0;
      end
      MUL0: state_nxt = MUL1;
      MUL1: state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = (k == 2'd3) ? IDLE : MUL0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_q   <= '0;
      ai_q   <= '0;
      br_q   <= '0;
      bi_q   <= '0;
      k      <= 2'd0;
      acc_re <= '0;
      acc_im <= '0;
    end else begin
      if (accept) begin
        ar_q <= a_real;
        ai_q <= a_imag;
        br_q <= b_real;
        bi_q <= b_imag;
        k    <= 2'd0;
      end
      if (emit && (k != 2'd3)) k <= k + 2'd1;
      if (state == MUL0) begin
        acc_re <= p_re_x;
        acc_im <= p_im_x;
      end else if (state == MUL1) begin
        acc_re <= acc_re + p_re_x;
        acc_im <= acc_im + p_im_x;
      end
    end
  end

  assign out_idx = k;
  assign c_real  = acc_re;
  assign c_imag  = acc_im;

endmodule

// File: tb/tb_cmat2x2_sequencer.sv
// Bench for cmat2x2_sequencer: table vectors, random operands/stalls against a plain-arithmetic model,
// plus hand-written reset, ignored-input and back-to-back sequences.
module tb_cmat2x2_sequencer;
  localparam int W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [4*W-1:0]    a_real, a_imag, b_real, b_imag;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_idx;
  logic signed [2*W+1:0] c_real, c_imag;
  logic              busy;

  int tests = 0;
  int fails = 0;

  cmat2x2_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .c_real(c_real), .c_imag(c_imag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ar, ai, br, bi;
    logic [71:0] er, ei;
    logic        use_model;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: textbook matrix product with integer complex arithmetic
  task automatic model(input logic [31:0] ar, ai, br, bi, output logic [71:0] er, ei);
    er = '0;
    ei = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        int sr, si;
        sr = 0;
        si = 0;
        for (int l = 0; l < 2; l++) begin
          int xr, xi, yr, yi;
          xr = int'($signed(ar[(2*i+l)*8 +: 8]));
          xi = int'($signed(ai[(2*i+l)*8 +: 8]));
          yr = int'($signed(br[(2*l+j)*8 +: 8]));
          yi = int'($signed(bi[(2*l+j)*8 +: 8]));
          sr += xr*yr - xi*yi;
          si += xr*yi + xi*yr;
        end
        er[(2*i+j)*18 +: 18] = sr[17:0];
        ei[(2*i+j)*18 +: 18] = si[17:0];
      end
  endtask

  // mode 0: drop in_valid after handshake; 1: drive other operands with in_valid until the last element;
  // 2: present the next operand set with in_valid held high for a back-to-back handshake
  task automatic run_op(input logic [31:0] xar, xai, xbr, xbi, input logic [71:0] er, ei,
                        input logic [31:0] stalls, input int mode,
                        input logic [31:0] nar, nai, nbr, nbi);
    int cyc, bound, tot, st;
    logic [1:0] hidx;
    logic [17:0] hre, him;
    a_real = xar; a_imag = xai; b_real = xbr; b_imag = xbi;
    in_valid = 1'b1;
    out_ready = 1'b1;
    bound = 0;
    while (!in_ready && bound < 40) begin @(negedge clk); bound++; end
    if (!in_ready) begin chk("hs_timeout", 0, 1); in_valid = 1'b0; return; end
    @(negedge clk);
    cyc = 1;
    chk("busy_after_hs", longint'({in_ready, busy}), 2'b01);
    if (mode == 0) in_valid = 1'b0;
    else begin
      a_real = nar; a_imag = nai; b_real = nbr; b_imag = nbi;
      in_valid = 1'b1;
    end
    tot = 0;
    for (int k = 0; k < 4; k++) begin
      bound = 0;
      while (!out_valid && bound < 20) begin @(negedge clk); cyc++; bound++; end
      if (!out_valid) begin chk("out_timeout", 0, 1); in_valid = 1'b0; return; end
      chk("valid_cycle", longint'(cyc), longint'(3 + 3*k + tot));
      chk("out_idx", longint'(out_idx), longint'(k));
      chk("c_real", longint'($signed(c_real)), longint'($signed(er[k*18 +: 18])));
      chk("c_imag", longint'($signed(c_imag)), longint'($signed(ei[k*18 +: 18])));
      chk("in_ready_low", longint'(in_ready), 0);
      if (mode == 1 && k == 3) in_valid = 1'b0;
      st = int'(stalls[k*8 +: 8]);
      tot += st;
      hidx = out_idx; hre = c_real; him = c_imag;
      for (int s = 0; s < st; s++) begin
        out_ready = 1'b0;
        @(negedge clk); cyc++;
        chk("stall_valid", longint'(out_valid), 1);
        chk("stall_hold", longint'(out_idx == hidx && c_real == hre && c_imag == him), 1);
      end
      out_ready = 1'b1;
      @(negedge clk); cyc++;
    end
    chk("end_cycle", longint'(cyc), longint'(13 + tot));
    chk("idle_ready", longint'({in_ready, busy}), 2'b10);
  endtask

  vec_t vecs[6];
  logic [71:0] er, ei;
  logic [31:0] r_ar, r_ai, r_br, r_bi;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;

    vecs[0] = '{ar: {8'd0, 8'd0, 8'd2, 8'd1}, ai: {8'd1, 8'd0, 8'd0, 8'd1},
                br: {8'd1, 8'd0, 8'd0, 8'd1}, bi: {8'd0, 8'd3, 8'd0, 8'd0},
                er: {18'sd0, -18'sd3, 18'sd2, 18'sd1}, ei: {18'sd1, 18'sd0, 18'sd0, 18'sd7},
                use_model: 1'b0};
    vecs[1] = '{ar: 32'h80808080, ai: 32'h80808080, br: 32'h80808080, bi: 32'h80808080,
                er: {4{18'sd0}}, ei: {4{18'sd65536}}, use_model: 1'b0};
    vecs[2] = '{ar: 32'h7f7f7f7f, ai: 32'h80808080, br: 32'h7f807f80, bi: 32'h807f807f,
                er: '0, ei: '0, use_model: 1'b1};
    for (int v = 3; v < 6; v++)
      vecs[v] = '{ar: $urandom, ai: $urandom, br: $urandom, bi: $urandom,
                  er: '0, ei: '0, use_model: 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_out_idx", longint'(out_idx), 0);
    chk("rst_c_real", longint'($signed(c_real)), 0);
    chk("rst_c_imag", longint'($signed(c_imag)), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].use_model) model(vecs[v].ar, vecs[v].ai, vecs[v].br, vecs[v].bi, er, ei);
      else begin er = vecs[v].er; ei = vecs[v].ei; end
      run_op(vecs[v].ar, vecs[v].ai, vecs[v].br, vecs[v].bi, er, ei, 32'd0, 0, '0, '0, '0, '0);
    end

    // Backpressure: five-cycle stall at k1, random stalls elsewhere
    r_ar = $urandom; r_ai = $urandom; r_br = $urandom; r_bi = $urandom;
    model(r_ar, r_ai, r_br, r_bi, er, ei);
    run_op(r_ar, r_ai, r_br, r_bi, er, ei,
           {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'd5, 8'($urandom_range(0, 3))},
           0, '0, '0, '0, '0);

    for (int n = 0; n < 8; n++) begin
      r_ar = $urandom; r_ai = $urandom; r_br = $urandom; r_bi = $urandom;
      model(r_ar, r_ai, r_br, r_bi, er, ei);
      run_op(r_ar, r_ai, r_br, r_bi, er, ei,
             {8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)),
              8'($urandom_range(0, 2)), 8'($urandom_range(0, 2))},
             0, '0, '0, '0, '0);
    end

    // Ignored input: different operands with in_valid high while busy
    r_ar = $urandom; r_ai = $urandom; r_br = $urandom; r_bi = $urandom;
    model(r_ar, r_ai, r_br, r_bi, er, ei);
    run_op(r_ar, r_ai, r_br, r_bi, er, ei, {8'd0, 8'd1, 8'd0, 8'd2}, 1,
           ~r_ar, r_bi, 32'h80808080, r_ai);

    // Reset during MUL1 of k=2
    a_real = $urandom; a_imag = $urandom; b_real = $urandom; b_imag = $urandom;
    in_valid = 1'b1;
    out_ready = 1'b1;
    chk("pre_rst_ready", longint'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_state", longint'({busy, out_valid, out_idx}), longint'({1'b1, 1'b0, 2'd2}));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", longint'(in_ready), 1);
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_out_idx", longint'(out_idx), 0);
    chk("mid_rst_c_real", longint'($signed(c_real)), 0);
    chk("mid_rst_c_imag", longint'($signed(c_imag)), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", longint'({in_ready, out_valid, busy}), 3'b100);

    r_br = $urandom; r_bi = $urandom;
    for (int k = 0; k < 4; k++) begin
      er[k*18 +: 18] = {{10{r_br[k*8+7]}}, r_br[k*8 +: 8]};
      ei[k*18 +: 18] = {{10{r_bi[k*8+7]}}, r_bi[k*8 +: 8]};
    end
    run_op({8'd1, 8'd0, 8'd0, 8'd1}, 32'd0, r_br, r_bi, er, ei, 32'd0, 0, '0, '0, '0, '0);

    // Back-to-back: second set waits with in_valid high and is taken at cycle 13
    r_ar = $urandom; r_ai = $urandom; r_br = $urandom; r_bi = $urandom;
    model(vecs[0].ar, vecs[0].ai, vecs[0].br, vecs[0].bi, er, ei);
    run_op(vecs[0].ar, vecs[0].ai, vecs[0].br, vecs[0].bi, er, ei, 32'd0, 2,
           r_ar, r_ai, r_br, r_bi);
    chk("b2b_ready", longint'({in_ready, in_valid}), 2'b11);
    model(r_ar, r_ai, r_br, r_bi, er, ei);
    run_op(r_ar, r_ai, r_br, r_bi, er, ei, 32'd0, 0, '0, '0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
